// File: rtl/fp_decode_serializer.sv
// Decodes an {S,E,F} float code to 12-bit two's complement and
// shifts the value out MSB-first as a framed serial stream.
module fp_decode_serializer #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  output logic [11:0] dec_out,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  state_e        state_q;
  logic          s_q;
  logic [2:0]    e_q;
  logic [3:0]    f_q;
  logic [11:0]   sh_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cyc_q;
  logic [GW-1:0] gap_q;
  logic [11:0]   dec_q;
  logic          so_q;
  logic          sv_q;
  logic          done_q;

  logic [11:0]   mag_d;
  logic [11:0]   val_d;

  // F=0 yields zero for any E or S, so no negative zero exists
  assign mag_d = {8'b0, f_q} << e_q;
  assign val_d = s_q ? (~mag_d + 12'd1) : mag_d;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign dec_out   = dec_q;
  assign ser_out   = so_q;
  assign ser_valid = sv_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      e_q     <= '0;
      f_q     <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      dec_q   <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_q     <= S;
            e_q     <= E;
            f_q     <= F;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          sh_q    <= val_d;
          dec_q   <= val_d;
          so_q    <= val_d[11];
          sv_q    <= 1'b1;
          bit_q   <= 4'd11;
          cyc_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q <= '0;
            if (bit_q != 4'd0) begin
              bit_q <= bit_q - 4'd1;
              sh_q  <= {sh_q[10:0], 1'b0};
              so_q  <= sh_q[10];
            end else begin
              sv_q    <= 1'b0;
              so_q    <= 1'b0;
              done_q  <= 1'b1;
              gap_q   <= '0;
              state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else gap_q <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_decode_serializer.sv
// Scoreboard bench: expected values pushed at handshake, frames
// reassembled from the serial line and checked on done.
module tb_fp_decode_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  logic        a_rst, a_v, a_rdy, a_s, a_so, a_sv, a_done;
  logic [2:0]  a_e;
  logic [3:0]  a_f;
  logic [11:0] a_dec;
  logic        b_rst, b_v, b_rdy, b_s, b_so, b_sv, b_done;
  logic [2:0]  b_e;
  logic [3:0]  b_f;
  logic [11:0] b_dec;

  fp_decode_serializer #(.BIT_CYCLES(1), .GAP_CYCLES(2)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_v), .in_ready(a_rdy),
    .S(a_s), .E(a_e), .F(a_f), .dec_out(a_dec),
    .ser_out(a_so), .ser_valid(a_sv), .done(a_done)
  );

  fp_decode_serializer #(.BIT_CYCLES(3), .GAP_CYCLES(1)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_v), .in_ready(b_rdy),
    .S(b_s), .E(b_e), .F(b_f), .dec_out(b_dec),
    .ser_out(b_so), .ser_valid(b_sv), .done(b_done)
  );

  logic [11:0] qa[$];
  logic [11:0] qb[$];
  bit          a_smp[$];
  bit          b_smp[$];
  int          a_hs = 0, b_hs = 0;
  int          a_hs_t = 0;

  function automatic logic [11:0] ref_v(input logic s,
                                        input logic [2:0] e,
                                        input logic [3:0] f);
    int m;
    m = int'(f) * (2 ** int'(e));
    if (s) m = -m;
    return m[11:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic frame_chk(input string nm, input int bc, input bit smp[$],
                           input logic [11:0] dec, input logic [11:0] exp);
    logic [11:0] w;
    int hb;
    w = '0;
    hb = 0;
    chk({nm, " frame length"}, 32'(smp.size()), 32'(12 * bc));
    if (smp.size() == 12 * bc) begin
      for (int i = 0; i < 12; i++) begin
        w[11-i] = smp[i*bc];
        for (int k = 0; k < bc; k++)
          if (smp[i*bc+k] != smp[i*bc]) hb++;
      end
    end
    chk({nm, " serial word"}, 32'(w), 32'(exp));
    chk({nm, " bit hold"}, 32'(hb), 32'd0);
    chk({nm, " dec_out"}, 32'(dec), 32'(exp));
  endtask

  // expected values enter the scoreboard on each accepted handshake
  always @(posedge clk) begin
    cyc_n++;
    if (a_v && a_rdy) begin
      qa.push_back(ref_v(a_s, a_e, a_f));
      a_hs++;
      a_hs_t = cyc_n;
    end
    if (b_v && b_rdy) begin
      qb.push_back(ref_v(b_s, b_e, b_f));
      b_hs++;
    end
  end

  always @(negedge clk) begin
    if (a_sv === 1'b0) chk("A ser_out idle", 32'(a_so), 32'd0);
    if (a_sv === 1'b1) a_smp.push_back(a_so);
    if (a_done === 1'b1) begin
      chk("A frame expected", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) frame_chk("A", 1, a_smp, a_dec, qa.pop_front());
      a_smp.delete();
    end else if (a_sv !== 1'b1) a_smp.delete();
  end

  always @(negedge clk) begin
    if (b_sv === 1'b0) chk("B ser_out idle", 32'(b_so), 32'd0);
    if (b_sv === 1'b1) b_smp.push_back(b_so);
    if (b_done === 1'b1) begin
      chk("B frame expected", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) frame_chk("B", 3, b_smp, b_dec, qb.pop_front());
      b_smp.delete();
    end else if (b_sv !== 1'b1) b_smp.delete();
  end

  task automatic send(input bit which, input logic s, input logic [2:0] e,
                      input logic [3:0] f, input bit hold, output int low);
    int n;
    low = 0;
    if (which) begin
      b_s = s; b_e = e; b_f = f; b_v = 1'b1; n = b_hs;
    end else begin
      a_s = s; a_e = e; a_f = f; a_v = 1'b1; n = a_hs;
    end
    for (int k = 0; k < 500; k++) begin
      if ((which ? b_hs : a_hs) != n) break;
      if (!(which ? b_rdy : a_rdy)) low++;
      @(negedge clk);
    end
    chk(which ? "B handshake" : "A handshake",
        32'((which ? b_hs : a_hs) - n), 32'd1);
    if (!hold) begin
      if (which) b_v = 1'b0;
      else a_v = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3000; k++) begin
      if (qa.size() == 0 && qb.size() == 0 && !a_sv && !b_sv) break;
      @(negedge clk);
    end
    chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    int low, t1, h;
    a_rst = 1'b1; b_rst = 1'b1;
    a_v = 1'b1; a_s = 1'b0; a_e = '0; a_f = '0;
    b_v = 1'b0; b_s = 1'b0; b_e = '0; b_f = '0;
    h = a_hs;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst in_ready", 32'(a_rdy), 32'd0);
      chk("rst dec_out", 32'(a_dec), 32'd0);
      chk("rst ser_valid", 32'(a_sv), 32'd0);
    end
    chk("rst done", 32'(a_done), 32'd0);
    chk("rst B dec_out", 32'(b_dec), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0; a_v = 1'b0;
    @(negedge clk);
    chk("in_ready after release", 32'(a_rdy), 32'd1);
    chk("no capture in reset", 32'(a_hs - h), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle after release", 32'(a_sv), 32'd0);

    send(0, 1'b0, 3'd2, 4'd11, 0, low); drain();
    send(0, 1'b1, 3'd7, 4'd15, 0, low); drain();
    send(0, 1'b0, 3'd7, 4'd15, 0, low); drain();
    send(0, 1'b1, 3'd0, 4'd0, 0, low); drain();
    send(0, 1'b0, 3'd5, 4'd0, 0, low); drain();

    send(0, 1'b0, 3'd0, 4'd4, 1, low);
    t1 = a_hs_t;
    send(0, 1'b1, 3'd5, 4'd13, 0, low);
    chk("b2b spacing", 32'(a_hs_t - t1), 32'd16);
    chk("b2b ready low", 32'(low), 32'd15);
    drain();

    for (int i = 0; i < 20; i++) begin
      send(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)),
           (i < 19) ? bit'($urandom_range(0, 1)) : 1'b0, low);
      if (!a_v) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    send(1, 1'b0, 3'd2, 4'd12, 0, low);
    for (int k = 0; k < 50; k++) begin
      if (b_sv) break;
      @(negedge clk);
    end
    chk("B frame started", 32'(b_sv), 32'd1);
    repeat (14) @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    chk("abort ser_valid", 32'(b_sv), 32'd0);
    chk("abort ser_out", 32'(b_so), 32'd0);
    chk("abort done", 32'(b_done), 32'd0);
    chk("abort dec_out", 32'(b_dec), 32'd0);
    if (qb.size() > 0) void'(qb.pop_back());
    repeat (5) @(negedge clk);
    send(1, 1'b0, 3'd0, 4'd4, 0, low);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
